dtc_rr_scheduler: RTL

Round-robin scheduler that shares a single combinational decision-tree classifier (12-bit feature vector in, 1-bit class out) between `NUM_REQ` requesters. It accepts one feature vector at a time over a valid/ready handshake and registers it onto the classifier input. It captures the class bit one cycle later and returns it to the granted requester over a per-requester response handshake. The block sits between the feature producers and one classifier instance, so each classifier in the design needs only one copy of its logic.

---
 rtl/dtc_rr_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dtc_rr_scheduler.sv
// Round-robin scheduler sharing one combinational decision-tree classifier among NUM_REQ requesters.
// Optional macro DTC_SCHED_STATS_EN adds saturating completion counters stat_total / stat_ones.
module dtc_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int FEAT_W  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FEAT_W-1:0] req_feat,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [FEAT_W-1:0]         cls_inp,
  input  logic                      cls_outp,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_class,
  input  logic [NUM_REQ-1:0]        rsp_ready,
`ifdef DTC_SCHED_STATS_EN
  output logic [15:0]               stat_total,
  output logic [15:0]               stat_ones,
`endif
  output logic                      busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_e;

  state_e            state_q, state_d;
  logic [FEAT_W-1:0] feat_q, feat_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              class_q, class_d;

  logic              arb_found;
  logic [GW-1:0]     arb_sel;
  logic [GW-1:0]     grant_nxt;
  logic              done;
  int                arb_idx;

  // Scan upward from rr_ptr with wrap-around; first pending requester wins.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = int'(rr_ptr_q) + k;
      if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
      if (!arb_found && req_valid[arb_idx]) begin
        arb_found = 1'b1;
        arb_sel   = GW'(arb_idx);
      end
    end
  end

  assign grant_nxt = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + GW'(1);

  always_comb begin
    state_d   = state_q;
    feat_d    = feat_q;
    grant_d   = grant_q;
    class_d   = class_q;
    rr_ptr_d  = rr_ptr_q;
    req_ready = '0;
    rsp_valid = '0;
    rsp_class = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          req_ready[arb_sel] = 1'b1;
          feat_d             = req_feat[int'(arb_sel)*FEAT_W +: FEAT_W];
          grant_d            = arb_sel;
          state_d            = EVAL;
        end
      end
      EVAL: begin
        class_d = cls_outp;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        rsp_class          = class_q;
        // Only the granted requester's ready can retire the result.
        if (rsp_ready[grant_q]) begin
          done     = 1'b1;
          rr_ptr_d = grant_nxt;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      feat_q   <= '0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      class_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      feat_q   <= feat_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      class_q  <= class_d;
    end
  end

  assign cls_inp = feat_q;
  assign busy    = (state_q != IDLE);

`ifdef DTC_SCHED_STATS_EN
  logic [15:0] stat_total_q, stat_total_d;
  logic [15:0] stat_ones_q, stat_ones_d;

  always_comb begin
    stat_total_d = stat_total_q;
    stat_ones_d  = stat_ones_q;
    if (done) begin
      if (stat_total_q != 16'hFFFF) stat_total_d = stat_total_q + 16'd1;
      if (class_q && (stat_ones_q != 16'hFFFF)) stat_ones_d = stat_ones_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total_q <= '0;
      stat_ones_q  <= '0;
    end else begin
      stat_total_q <= stat_total_d;
      stat_ones_q  <= stat_ones_d;
    end
  end

  assign stat_total = stat_total_q;
  assign stat_ones  = stat_ones_q;
`endif

endmodule
